// File: rtl/pon_burst_timing_gen.sv
// Upstream PON burst framing generator: turns shadowed preamble/burst/period
// configuration into registered per-cycle TX framing strobes.
`timescale 1ns/1ps
module pon_burst_timing_gen #(
    parameter int CFG_W = 32,
    parameter int CNT_W = 32
) (
    input  logic             hb0_gtwiz_userclk_tx_usrclk2_int,
    input  logic             hb0_gtwiz_reset_n,
    input  logic             enable,
    input  logic [CFG_W-1:0] preamble_length,
    input  logic [CFG_W-1:0] burst_length,
    input  logic [CFG_W-1:0] burst_period,
    output logic             burst_en,
    output logic             preamble_active,
    output logic             payload_active,
    output logic             burst_sof,
    output logic             burst_eof,
    output logic [CNT_W-1:0] burst_count,
    output logic             config_error,
    output logic             busy
);

    typedef enum logic [1:0] {IDLE, PREAMBLE, PAYLOAD, GAP} state_t;

    localparam logic [CFG_W-1:0] ONE = CFG_W'(1);
    localparam logic [CFG_W-1:0] TWO = CFG_W'(2);
    localparam logic [CFG_W:0]   ONE_W = (CFG_W+1)'(1);

    state_t           state_q, state_d;
    logic [CFG_W-1:0] pre_q, pre_d, len_q, len_d, per_q, per_d, cnt_q, cnt_d;
    logic             cerr_q, cerr_d;
    logic             burst_en_q, burst_en_d, pre_act_q, pre_act_d;
    logic             pay_act_q, pay_act_d, sof_q, sof_d, eof_q, eof_d;
    logic             busy_q, busy_d;
    logic [CNT_W-1:0] count_q;

    logic [CFG_W:0]   in_sum, pl_end;
    logic             in_valid, launch, run_d, boundary;

    always_comb begin
        // One extra bit on the sum so pre+len cannot wrap into a false "valid".
        in_sum   = {1'b0, preamble_length} + {1'b0, burst_length};
        in_valid = (burst_length != '0) && (burst_period >= TWO) &&
                   (in_sum <= {1'b0, burst_period});

        state_d  = state_q;
        pre_d    = pre_q;
        len_d    = len_q;
        per_d    = per_q;
        cnt_d    = cnt_q;
        cerr_d   = cerr_q;
        launch   = 1'b0;
        run_d    = (state_q != IDLE);
        boundary = (state_q != IDLE) && (cnt_q == per_q - ONE);

        if (state_q == IDLE) begin
            launch = enable;
        end else if (boundary) begin
            launch = enable;
            if (!enable) run_d = 1'b0;
        end else begin
            cnt_d = cnt_q + ONE;
        end

        if (launch) begin
            pre_d  = preamble_length;
            len_d  = burst_length;
            per_d  = burst_period;
            cerr_d = !in_valid;
            cnt_d  = '0;
            run_d  = in_valid;
        end

        pl_end = {1'b0, pre_d} + {1'b0, len_d};
        if (!run_d)                           state_d = IDLE;
        else if (cnt_d < pre_d)               state_d = PREAMBLE;
        else if ({1'b0, cnt_d} < pl_end)      state_d = PAYLOAD;
        else                                  state_d = GAP;

        // Strobes are decoded from the next state so they leave as flops.
        pre_act_d  = (state_d == PREAMBLE);
        pay_act_d  = (state_d == PAYLOAD);
        burst_en_d = pre_act_d || pay_act_d;
        sof_d      = pay_act_d && (cnt_d == pre_d);
        eof_d      = pay_act_d && ({1'b0, cnt_d} == pl_end - ONE_W);
        busy_d     = (state_d != IDLE);
    end

    always_ff @(posedge hb0_gtwiz_userclk_tx_usrclk2_int or negedge hb0_gtwiz_reset_n) begin
        if (!hb0_gtwiz_reset_n) begin
            state_q    <= IDLE;
            pre_q      <= '0;
            len_q      <= '0;
            per_q      <= '0;
            cnt_q      <= '0;
            cerr_q     <= 1'b0;
            burst_en_q <= 1'b0;
            pre_act_q  <= 1'b0;
            pay_act_q  <= 1'b0;
            sof_q      <= 1'b0;
            eof_q      <= 1'b0;
            busy_q     <= 1'b0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            pre_q      <= pre_d;
            len_q      <= len_d;
            per_q      <= per_d;
            cnt_q      <= cnt_d;
            cerr_q     <= cerr_d;
            burst_en_q <= burst_en_d;
            pre_act_q  <= pre_act_d;
            pay_act_q  <= pay_act_d;
            sof_q      <= sof_d;
            eof_q      <= eof_d;
            busy_q     <= busy_d;
            count_q    <= count_q + {{(CNT_W-1){1'b0}}, eof_q};
        end
    end

    assign burst_en        = burst_en_q;
    assign preamble_active = pre_act_q;
    assign payload_active  = pay_act_q;
    assign burst_sof       = sof_q;
    assign burst_eof       = eof_q;
    assign burst_count     = count_q;
    assign config_error    = cerr_q;
    assign busy            = busy_q;

endmodule

// File: tb/tb_pon_burst_timing_gen.sv
// Bench for pon_burst_timing_gen: period-position reference model feeds a
// per-cycle expected-output queue that a negedge monitor drains and compares.
`timescale 1ns/1ps
module tb_pon_burst_timing_gen;
    localparam int CFG_W = 8;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             enable = 1'b0;
    logic [CFG_W-1:0] pre_i = '0, len_i = '0, per_i = '0;
    logic             burst_en, preamble_active, payload_active, burst_sof, burst_eof;
    logic             config_error, busy;
    logic [CNT_W-1:0] burst_count;

    int errors = 0;
    int checks = 0;

    typedef logic [10:0] vec_t;
    vec_t exp_q[$];

    pon_burst_timing_gen #(.CFG_W(CFG_W), .CNT_W(CNT_W)) dut (
        .hb0_gtwiz_userclk_tx_usrclk2_int(clk),
        .hb0_gtwiz_reset_n(rst_n),
        .enable(enable),
        .preamble_length(pre_i),
        .burst_length(len_i),
        .burst_period(per_i),
        .burst_en(burst_en),
        .preamble_active(preamble_active),
        .payload_active(payload_active),
        .burst_sof(burst_sof),
        .burst_eof(burst_eof),
        .burst_count(burst_count),
        .config_error(config_error),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // Reference: position k within the current period plus the latched config.
    bit m_run, m_cerr, m_last_eof;
    int m_k, m_pre, m_len, m_per, m_cnt;

    always @(posedge clk) begin : model
        bit launch, valid, en, pa, pl, sof, eof;
        if (!rst_n) begin
            m_run = 0; m_cerr = 0; m_last_eof = 0; m_k = 0; m_cnt = 0;
            exp_q.push_back('0);
        end else begin
            if (m_last_eof) m_cnt = (m_cnt + 1) % (1 << CNT_W);
            launch = 0;
            if (!m_run) launch = enable;
            else if (m_k == m_per - 1) begin
                launch = enable;
                if (!enable) m_run = 0;
            end else m_k++;
            if (launch) begin
                valid  = (int'(len_i) >= 1) && (int'(per_i) >= 2) &&
                         (int'(pre_i) + int'(len_i) <= int'(per_i));
                m_cerr = !valid;
                m_run  = valid;
                m_k    = 0;
                m_pre  = pre_i; m_len = len_i; m_per = per_i;
            end
            en  = m_run && (m_k < m_pre + m_len);
            pa  = m_run && (m_k < m_pre);
            pl  = en && !pa;
            sof = pl && (m_k == m_pre);
            eof = pl && (m_k == m_pre + m_len - 1);
            m_last_eof = eof;
            exp_q.push_back({en, pa, pl, sof, eof, m_run, m_cerr, 4'(m_cnt)});
        end
    end

    always @(negedge clk) begin : monitor
        vec_t got, e;
        got = {burst_en, preamble_active, payload_active, burst_sof, burst_eof,
               busy, config_error, burst_count};
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL queue_empty t=%0t got=%b", $time, got);
        end else begin
            e = exp_q.pop_front();
            if (!rst_n) e = '0;
            if (got !== e) begin
                errors++;
                $display("FAIL cycle_vec t=%0t got=%b exp=%b (en,pre,pay,sof,eof,busy,cerr,cnt)",
                         $time, got, e);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_cfg(input int p, input int l, input int r);
        pre_i = CFG_W'(p); len_i = CFG_W'(l); per_i = CFG_W'(r);
    endtask

    // sel: 0 = payload_active, 1 = not busy, 2 = burst_sof
    task automatic wait_until(input int sel, input int limit);
        int i = 0;
        while (!((sel == 0) ? payload_active : (sel == 1) ? !busy : burst_sof) && i < limit) begin
            tick(1);
            i++;
        end
        checks++;
        if (i >= limit) begin
            errors++;
            $display("FAIL wait_timeout sel=%0d got=timeout exp=event within %0d", sel, limit);
        end
    endtask

    initial begin
        tick(3);
        rst_n = 1'b1;
        tick(1);

        // Basic burst, three periods
        set_cfg(4, 10, 20); enable = 1'b1;
        tick(62);

        // Live reconfiguration at cycle 7
        wait_until(2, 40);
        tick(3);
        set_cfg(4, 6, 20);
        tick(40);
        enable = 1'b0;
        wait_until(1, 40);

        // Zero preamble, single-cycle payload
        set_cfg(0, 1, 2); enable = 1'b1;
        tick(20);
        enable = 1'b0;
        wait_until(1, 10);

        // Invalid then corrected config
        set_cfg(10, 15, 20); enable = 1'b1;
        tick(10);
        set_cfg(10, 10, 20);
        tick(45);
        enable = 1'b0;
        wait_until(1, 40);

        // Enable drop at cycle 5
        set_cfg(4, 10, 20); enable = 1'b1;
        tick(6);
        enable = 1'b0;
        wait_until(1, 40);

        // Back to back, pre+len == per
        set_cfg(4, 10, 14); enable = 1'b1;
        tick(50);

        // Reset mid-payload
        wait_until(0, 30);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({burst_en, preamble_active, payload_active, burst_sof, burst_eof, busy,
             config_error, burst_count} !== 11'b0) begin
            errors++;
            $display("FAIL async_reset got=%b exp=0", {burst_en, payload_active, busy, burst_count});
        end
        tick(2);
        rst_n = 1'b1;
        enable = 1'b0;
        tick(2);

        // Counter wrap: 17 single-cycle bursts
        set_cfg(0, 1, 2); enable = 1'b1;
        tick(34);
        checks++;
        if (burst_count !== 4'd1) begin
            errors++;
            $display("FAIL count_wrap got=%0d exp=1", burst_count);
        end
        enable = 1'b0;
        wait_until(1, 10);

        // Randomized segments
        for (int s = 0; s < 60; s++) begin
            if ($urandom_range(0, 7) == 0)
                set_cfg($urandom_range(100, 255), $urandom_range(100, 255), $urandom_range(200, 255));
            else
                set_cfg($urandom_range(0, 6), $urandom_range(0, 10), $urandom_range(0, 25));
            enable = ($urandom_range(0, 3) != 0);
            tick($urandom_range(1, 40));
        end
        enable = 1'b0;
        tick(300);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/pon_burst_timing_gen.md
Name: pon_burst_timing_gen

Overview:
Upstream burst scheduler for the PON emulation datapath. It turns the VIO-driven preamble length, burst length and burst period into the per-cycle transmit framing strobes that the burst-mode TX data path and laser enable consume. Configuration is shadowed once per period, so live VIO writes never corrupt a burst in flight. It runs in the GT TX user clock domain, the same domain as the VIO.

Parameters:
CFG_W, 32, width of the preamble, burst and period configuration inputs, in TX user clock cycles.
CNT_W, 32, width of the completed-burst counter.

Ports:
hb0_gtwiz_userclk_tx_usrclk2_int  input  1  single clock; all logic is rising-edge.
hb0_gtwiz_reset_n  input  1  asynchronous active-low reset.
enable  input  1  run request, level-sensitive.
preamble_length  input  CFG_W  preamble cycles per burst; 0 is legal.
burst_length  input  CFG_W  payload cycles per burst; must be at least 1.
burst_period  input  CFG_W  cycles from one burst start to the next.
burst_en  output  1  laser/TX enable; high during PREAMBLE and PAYLOAD.
preamble_active  output  1  high in PREAMBLE.
payload_active  output  1  high in PAYLOAD; the TX path sends one payload word per cycle.
burst_sof  output  1  one-cycle pulse on the first PAYLOAD cycle.
burst_eof  output  1  one-cycle pulse on the last PAYLOAD cycle.
burst_count  output  CNT_W  completed bursts; wraps modulo 2^CNT_W.
config_error  output  1  the config last sampled is invalid.
busy  output  1  state is not IDLE.

Behaviour:
- Clock and reset: one clock, hb0_gtwiz_userclk_tx_usrclk2_int. Reset hb0_gtwiz_reset_n is asynchronous and active-low.
  - Reset asserts asynchronously. All outputs go to 0 immediately, including mid-burst; state goes to IDLE.
  - Deassertion is used synchronously.
- All outputs are registered and decoded from state and counters. No combinational path from input to output.
- States: IDLE, PREAMBLE, PAYLOAD, GAP.
- Config sampling ("launch") happens in IDLE when enable=1, or at a period boundary when enable=1.
  - Latch pre/len/per into shadow registers.
  - Validity check uses a CFG_W+1-bit sum: valid = (len>=1) && (per>=2) && (pre+len <= per).
  - If invalid: config_error=1, go to or stay in IDLE, no burst.
  - config_error is re-evaluated at each launch attempt. It clears when a valid config is latched.
- Launch timing:
  - enable first seen high in IDLE at cycle N → burst_en high from cycle N+1.
  - That cycle is "cycle 0" of the period.
- The period counter counts 0..per-1 from cycle 0, per burst.
  - PREAMBLE occupies cycles 0..pre-1. If pre=0, PREAMBLE is skipped and PAYLOAD starts at cycle 0.
  - PAYLOAD occupies cycles pre..pre+len-1.
  - burst_sof fires at cycle pre; burst_eof fires at cycle pre+len-1. If len=1, sof and eof fire in the same cycle.
  - GAP occupies the remaining cycles through per-1. If pre+len==per, GAP is skipped and bursts run back to back.
- Period boundary (cycle per-1):
  - If enable=1: re-launch with freshly sampled config. Next cycle is cycle 0 of the new period, so there is no dead cycle between periods.
  - If enable=0: go to IDLE.
- enable dropping mid-period does not truncate anything. The current burst and gap complete; enable is only sampled at boundaries and in IDLE.
- Config inputs changing mid-period have no effect until the next launch.
- burst_count increments on the cycle after burst_eof, wrapping modulo 2^CNT_W.
- busy=1 whenever state is not IDLE.

Test Plan:
- Basic burst: pre=4, len=10, per=20, enable held high → per period, with cycle 0 = first burst_en cycle:
  - burst_en high on cycles 0-13; preamble_active on 0-3; payload_active on 4-13.
  - burst_sof at cycle 4; burst_eof at cycle 13.
  - Next burst_en rise at cycle 20; burst_count=3 after 3 periods.
- Zero preamble and len=1: pre=0, len=1, per=2 → burst_en high on alternate cycles; sof and eof coincide; preamble_active never asserts.
- Invalid config: pre=10, len=15, per=20 → config_error=1, burst_en stays 0, busy=0. Then set len=10 → config_error=0 on the next launch and bursts start.
- Live reconfiguration: change len 10→6 at cycle 7 of a period → current burst still ends at cycle 13; next period's payload spans cycles 4-9.
- enable drop and back-to-back:
  - Deassert enable at cycle 5 → burst completes, burst_en=0 from cycle 14, busy=0 after cycle 19.
  - Separately, pre+len=per=14 → burst_en stays high continuously, with burst_sof every 14 cycles.
- Reset mid-burst and wrap:
  - Pulse hb0_gtwiz_reset_n low during PAYLOAD → all outputs 0 in the same cycle, state IDLE. Restart is clean on the next enable.
  - With CNT_W=4, run 17 bursts → burst_count wraps to 1.
